regfile_init_loader: RTL and testbench

Streams (register index, value) pairs into the processor register file after reset and holds the processor until loading completes. It is the writer-side counterpart to the end-of-run register readout the benches perform. It sits between a host/bench stream source and the regfile write port, and gates `processor_clock`-domain execution through `proc_hold`. It buffers incoming pairs in a small FIFO, drops writes to r0, and can optionally read back each write for self-check.

---
 rtl/regfile_init_loader.sv | 140 ++++++++++++++
 tb/tb_regfile_init_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_init_loader.sv
// Post-reset register file loader: buffers (index, value) pairs in a small FIFO,
// writes them to the regfile, and holds the processor until the last pair lands.
// Optional readback self-check of every write is built when LOADER_READBACK_EN is defined.
module regfile_init_loader #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_reg,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             ctrl_writeEnable,
  output logic [4:0]       ctrl_writeReg,
  output logic [31:0]      data_writeReg,
  output logic [4:0]       ctrl_readRegA,
  input  logic [31:0]      data_readRegA,
  output logic             proc_hold,
  output logic             load_done,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] skip_count,
  output logic [7:0]       err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {LOAD, VERIFY, DONE} state_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } pair_t;

  state_t        state;
  pair_t         mem [DEPTH];
  pair_t         head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          last_pend;
  logic          push, pop, go_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign head     = mem[rd_ptr];
  assign in_ready = (count != FULL_CNT) && (state != DONE);
  assign push     = in_valid && in_ready;

`ifdef LOADER_READBACK_EN
  // A write cycle is always followed by its VERIFY cycle, so no pop while the pulse is up.
  assign pop     = (count != '0) && !last_pend &&
                   ((state == LOAD && !ctrl_writeEnable) || state == VERIFY);
  assign go_done = last_pend && ((state == LOAD && !ctrl_writeEnable) || state == VERIFY);
`else
  assign pop     = (count != '0) && !last_pend && (state == LOAD);
  assign go_done = last_pend && (state == LOAD);
`endif

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= '{idx: in_reg, data: in_data, last: in_last};

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state            <= LOAD;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      last_pend        <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      proc_hold        <= 1'b1;
      load_done        <= 1'b0;
      write_count      <= '0;
      skip_count       <= '0;
`ifdef LOADER_READBACK_EN
      ctrl_readRegA    <= '0;
      err_count        <= '0;
`endif
    end else begin
      ctrl_writeEnable <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head.idx != '0) begin
          ctrl_writeEnable <= 1'b1;
          ctrl_writeReg    <= head.idx;
          data_writeReg    <= head.data;
          write_count      <= sat_inc(write_count);
        end else begin
          skip_count <= sat_inc(skip_count);
        end
        if (head.last) last_pend <= 1'b1;
      end

      case (state)
`ifdef LOADER_READBACK_EN
        LOAD:
          if (ctrl_writeEnable) begin
            state         <= VERIFY;
            ctrl_readRegA <= ctrl_writeReg;
          end
        VERIFY: begin
          // data_writeReg still holds the checked value: nothing was popped during the write cycle.
          if (data_readRegA != data_writeReg && err_count != 8'hff)
            err_count <= err_count + 8'd1;
          ctrl_readRegA <= '0;
          state         <= LOAD;
        end
`endif
        default: ;
      endcase

      // Anything queued behind the last pair is discarded.
      if (go_done) begin
        state     <= DONE;
        proc_hold <= 1'b0;
        load_done <= 1'b1;
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end
    end
  end

`ifndef LOADER_READBACK_EN
  logic unused_rd;
  assign unused_rd     = ^data_readRegA;
  assign ctrl_readRegA = '0;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_regfile_init_loader.sv
// Directed bench for regfile_init_loader: regfile model with a corrupting read of r7,
// write log captured at the active edge, hand-computed expectations per scenario.
module tb_regfile_init_loader;

`ifdef LOADER_READBACK_EN
  localparam int WSTEP = 2, HOLD_D = 2, EXP_ERR = 1;
`else
  localparam int WSTEP = 1, HOLD_D = 1, EXP_ERR = 0;
`endif

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [31:0] data_readRegA;
  logic        proc_hold, load_done;
  logic [5:0]  write_count, skip_count;
  logic [7:0]  err_count;

  regfile_init_loader #(.DEPTH(4), .CNT_W(6)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data), .in_last(in_last),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .data_readRegA(data_readRegA),
    .proc_hold(proc_hold), .load_done(load_done),
    .write_count(write_count), .skip_count(skip_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clock) if (ctrl_writeEnable && ctrl_writeReg != 0) rf[ctrl_writeReg] <= data_writeReg;
  assign data_readRegA = (ctrl_readRegA == 5'd7) ? (rf[7] ^ 32'h1) : rf[ctrl_readRegA];

  typedef struct { int idx; int data; int cyc; } wr_t;
  wr_t wq[$];
  int  cyc = 0, fall_cyc = -1;
  bit  prev_hold = 1'b1;
  int  n_chk = 0, n_err = 0;

  // Pre-edge values at the active edge: what the regfile actually saw that cycle.
  always @(posedge clock) begin
    if (ctrl_reset_n && ctrl_writeEnable)
      wq.push_back('{int'(ctrl_writeReg), int'(data_writeReg), cyc});
    if (prev_hold && !proc_hold) fall_cyc = cyc;
    prev_hold = proc_hold;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] r, input logic [31:0] d, input logic l);
    bit ok;
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1; in_reg = r; in_data = d; in_last = l;
    do begin
      ok = in_ready;
      @(posedge clock);
      if (!ok) @(negedge clock);
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!load_done && n < bound) begin @(negedge clock); n++; end
    chk("done_timeout", load_done, 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    wq.delete();
    fall_cyc = -1;
  endtask

  initial begin
    int n;
    #1 ctrl_reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_hold", proc_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_wcnt", write_count, 0);
    chk("rst_rda", ctrl_readRegA, 0);
    ctrl_reset_n = 1'b1;

    // Back-to-back four pairs.
    send(5'd1, 32'd5, 0); send(5'd2, 32'd3, 0); send(5'd3, 32'd8, 0); send(5'd4, 32'd2, 1);
    idle();
    wait_done(60);
    chk("t1_nwr", wq.size(), 4);
    if (wq.size() == 4) begin
      chk("t1_idx0", wq[0].idx, 1);  chk("t1_dat0", wq[0].data, 5);
      chk("t1_idx1", wq[1].idx, 2);  chk("t1_dat1", wq[1].data, 3);
      chk("t1_idx2", wq[2].idx, 3);  chk("t1_dat2", wq[2].data, 8);
      chk("t1_idx3", wq[3].idx, 4);  chk("t1_dat3", wq[3].data, 2);
      chk("t1_spacing", wq[3].cyc - wq[0].cyc, 3 * WSTEP);
      chk("t1_hold_fall", fall_cyc - wq[3].cyc, HOLD_D);
    end
    chk("t1_wcnt", write_count, 4);
    chk("t1_hold", proc_hold, 0);

    // Input after DONE is refused.
    in_valid = 1'b1; in_reg = 5'd6; in_data = 32'd77;
    for (int i = 0; i < 3; i++) begin
      chk("done_ready", in_ready, 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("done_nwr", wq.size(), 4);
    chk("done_wcnt", write_count, 4);
    chk("done_skip", skip_count, 0);
    chk("done_sticky", load_done, 1);

    // r0 pair is dropped.
    do_reset();
    send(5'd0, 32'd99, 0); send(5'd5, 32'd1, 1);
    idle();
    wait_done(40);
    chk("t2_nwr", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("t2_idx", wq[0].idx, 5);
      chk("t2_dat", wq[0].data, 1);
    end
    chk("t2_skip", skip_count, 1);
    chk("t2_wcnt", write_count, 1);
    chk("t2_done", load_done, 1);

    // Six pairs streamed with in_valid held: order and count preserved.
    do_reset();
    for (int i = 0; i < 6; i++) send(5'(11 + i), 32'(100 + i), i == 5);
    idle();
    wait_done(80);
    chk("t3_nwr", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      chk("t3_idx", wq[i].idx, 11 + i);
      chk("t3_dat", wq[i].data, 100 + i);
    end
    chk("t3_wcnt", write_count, 6);

    // Reset in the middle of a load, then reload.
    do_reset();
    send(5'd1, 32'd11, 0); send(5'd2, 32'd22, 0); send(5'd3, 32'd33, 0);
    n = 0;
    while (wq.size() < 2 && n < 20) begin @(negedge clock); n++; end
    chk("t4_two_written", wq.size() >= 2, 1);
    ctrl_reset_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("t4_rst_we", ctrl_writeEnable, 0);
    chk("t4_rst_wreg", ctrl_writeReg, 0);
    chk("t4_rst_wdat", data_writeReg, 0);
    chk("t4_rst_hold", proc_hold, 1);
    chk("t4_rst_wcnt", write_count, 0);
    chk("t4_rst_ready", in_ready, 1);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    wq.delete();
    fall_cyc = -1;
    send(5'd9, 32'd345, 0); send(5'd10, 32'd567, 1);
    idle();
    wait_done(40);
    chk("t4_wcnt", write_count, 2);
    chk("t4_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t4_dat0", wq[0].data, 345);
      chk("t4_idx1", wq[1].idx, 10);
      chk("t4_dat1", wq[1].data, 567);
    end

    // r7 reads back corrupted; only counted when readback is built in.
    do_reset();
    send(5'd7, 32'd20, 1);
    idle();
    wait_done(40);
    chk("t5_err", err_count, EXP_ERR);
    chk("t5_nwr", wq.size(), 1);
    if (wq.size() == 1) chk("t5_hold_fall", fall_cyc - wq[0].cyc, HOLD_D);
    chk("t5_rda_idle", ctrl_readRegA, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
